// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: streams NUM_LEDS GRB words from a synchronous pixel RAM
// into the single-LED bit driver, then holds the line idle for the latch gap.
module ws2812_frame_ctrl #(
  parameter int NUM_LEDS     = 16,
  parameter int ADDR_W       = 4,
  parameter int LATCH_CYCLES = 18200,
  parameter int ACK_TIMEOUT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_req,
  input  logic              auto_refresh,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              ack_err,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic [23:0]       drv_grb,
  output logic              drv_start,
  input  logic              drv_end
);

  localparam int LAT_W = $clog2(LATCH_CYCLES + 1);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [ACK_W-1:0]  ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LOAD      = 3'd2,
    S_START     = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_LATCH     = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic              grb_loaded_q, grb_loaded_d;
  logic [23:0]       drv_grb_q, drv_grb_d;
  logic              frame_busy_q, frame_busy_d;
  logic              frame_done_q, frame_done_d;
  logic              ack_err_q, ack_err_d;
  logic              pix_rd_q, pix_rd_d;
  logic              drv_start_q, drv_start_d;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pix_addr_q   <= {ADDR_W{1'b0}};
      lat_cnt_q    <= {LAT_W{1'b0}};
      ack_cnt_q    <= {ACK_W{1'b0}};
      grb_loaded_q <= 1'b0;
      drv_grb_q    <= 24'h000000;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      ack_err_q    <= 1'b0;
      pix_rd_q     <= 1'b0;
      drv_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_addr_q   <= pix_addr_d;
      lat_cnt_q    <= lat_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      grb_loaded_q <= grb_loaded_d;
      drv_grb_q    <= drv_grb_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
      ack_err_q    <= ack_err_d;
      pix_rd_q     <= pix_rd_d;
      drv_start_q  <= drv_start_d;
    end
  end

  // Next-state and next-output logic; pulse outputs are set on entry to their state
  always_comb begin
    state_d      = state_q;
    pix_addr_d   = pix_addr_q;
    lat_cnt_d    = lat_cnt_q;
    ack_cnt_d    = ack_cnt_q;
    grb_loaded_d = grb_loaded_q;
    drv_grb_d    = drv_grb_q;
    frame_busy_d = frame_busy_q;
    frame_done_d = 1'b0;
    ack_err_d    = ack_err_q;
    pix_rd_d     = 1'b0;
    drv_start_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A request landing on the frame_done cycle belongs to the finished frame
        if (frame_req && !frame_done_q) begin
          state_d      = S_FETCH;
          pix_addr_d   = {ADDR_W{1'b0}};
          frame_busy_d = 1'b1;
          ack_err_d    = 1'b0;
          pix_rd_d     = 1'b1;
        end else begin
          frame_busy_d = 1'b0;
        end
      end
      S_FETCH: begin
        state_d      = S_LOAD;
        grb_loaded_d = 1'b0;
      end
      S_LOAD: begin
        // Capture the RAM word once so a long wait for the driver cannot pick up stale data
        if (!grb_loaded_q) begin
          drv_grb_d    = pix_data;
          grb_loaded_d = 1'b1;
        end else begin
          grb_loaded_d = 1'b1;
        end
        if (drv_end) begin
          state_d     = S_START;
          drv_start_d = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_START: begin
        state_d   = S_WAIT_ACK;
        ack_cnt_d = {ACK_W{1'b0}};
      end
      S_WAIT_ACK: begin
        if (!drv_end) begin
          state_d = S_WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          state_d   = S_LATCH;
          ack_err_d = 1'b1;
          lat_cnt_d = {LAT_W{1'b0}};
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (drv_end) begin
          if (pix_addr_q == LAST_IDX) begin
            state_d   = S_LATCH;
            lat_cnt_d = {LAT_W{1'b0}};
          end else begin
            state_d    = S_FETCH;
            pix_addr_d = pix_addr_q + ADDR_W'(1);
            pix_rd_d   = 1'b1;
          end
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_LATCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          frame_done_d = 1'b1;
          lat_cnt_d    = {LAT_W{1'b0}};
          if (auto_refresh) begin
            state_d      = S_FETCH;
            pix_addr_d   = {ADDR_W{1'b0}};
            pix_rd_d     = 1'b1;
            ack_err_d    = 1'b0;
            frame_busy_d = 1'b1;
          end else begin
            state_d      = S_IDLE;
            frame_busy_d = 1'b0;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      default: begin
        state_d      = S_IDLE;
        frame_busy_d = 1'b0;
      end
    endcase
  end

  assign frame_busy = frame_busy_q;
  assign frame_done = frame_done_q;
  assign ack_err    = ack_err_q;
  assign pix_rd     = pix_rd_q;
  assign pix_addr   = pix_addr_q;
  assign drv_grb    = drv_grb_q;
  assign drv_start  = drv_start_q;

endmodule
